// File: rtl/seq_muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// seq_muldiv_unit_pkg
//   Shared definitions for the iterative multiply/divide unit:
//   FSM state encoding, operation codes and the default operand width.
// ---------------------------------------------------------------------------
package seq_muldiv_unit_pkg;

  localparam int WIDTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/muldiv_step.sv
// ---------------------------------------------------------------------------
// muldiv_step
//   Combinational single iteration of the multiply/divide unit.
//   Ports:
//     i_op    operation select (OP_MUL / OP_DIV)
//     i_acc   current accumulator (2*WIDTH+1 bits)
//               MUL: {upper partial product (WIDTH+1), multiplier bits (WIDTH)}
//               DIV: remainder in [WIDTH:0], upper bits zero
//     i_quo   DIV: dividend bits shifting out / quotient bits shifting in
//     i_a     multiplicand (MUL)
//     i_b     divisor (DIV)
//     o_acc   next accumulator
//     o_quo   next quotient register
// ---------------------------------------------------------------------------
module muldiv_step
  import seq_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_op,
  input  logic [2*WIDTH:0] i_acc,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [2*WIDTH:0] o_acc,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_trial;

  always_comb begin
    // MUL: add the multiplicand into the upper half when the current
    // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
    w_sum    = i_acc[2*WIDTH:WIDTH] + (i_acc[0] ? {1'b0, i_a} : {(WIDTH+1){1'b0}});
    // DIV: bring the next dividend MSB into the remainder, then trial subtract.
    // The extra top bit of w_trial is the borrow (negative result).
    w_rem_sh = {i_acc[WIDTH-1:0], i_quo[WIDTH-1]};
    w_trial  = {1'b0, w_rem_sh} - {2'b00, i_b};

    o_acc = i_acc;
    o_quo = i_quo;
    if (i_op == OP_MUL) begin
      o_acc = {1'b0, w_sum, i_acc[WIDTH-1:1]};
    end else if (!w_trial[WIDTH+1]) begin
      o_acc = {{WIDTH{1'b0}}, w_trial[WIDTH:0]};
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {{WIDTH{1'b0}}, w_rem_sh};
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_muldiv_unit.sv
// ---------------------------------------------------------------------------
// seq_muldiv_unit
//   Iterative unsigned WIDTH x WIDTH multiply / WIDTH / WIDTH divide.
//   One shift-add (MUL) or restoring-subtract (DIV) step per clock.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; results held
//   ST_RUN  | one step per cycle, WIDTH steps total
//   ST_DONE | done strobe for one cycle; a new start is accepted here
//
//   Ports:
//     i_clk        clock
//     i_rst_n      synchronous active-low reset
//     i_start      operation request (accepted in IDLE or DONE)
//     i_op         0 = MUL, 1 = DIV
//     i_a, i_b     multiplicand/dividend, multiplier/divisor
//     o_busy       high while running
//     o_done       one-cycle completion strobe
//     o_result_lo  MUL: product low half;  DIV: quotient
//     o_result_hi  MUL: product high half; DIV: remainder
//     o_err        divide by zero, held until the next accepted start
// ---------------------------------------------------------------------------
module seq_muldiv_unit
  import seq_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result_lo,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_err
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2*WIDTH:0] r_acc;
  logic [WIDTH-1:0] r_quo;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_result_lo;
  logic [WIDTH-1:0] r_result_hi;

  logic [2*WIDTH:0] w_acc;
  logic [WIDTH-1:0] w_quo;
  logic             w_accept;
  logic             w_div0;
  logic             w_last;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_op  (r_op),
    .i_acc (r_acc),
    .i_quo (r_quo),
    .i_a   (r_a),
    .i_b   (r_b),
    .o_acc (w_acc),
    .o_quo (w_quo)
  );

  assign w_accept = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_div0   = (i_op == OP_DIV) && (i_b == {WIDTH{1'b0}});
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_op        <= OP_MUL;
      r_a         <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_quo       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_result_lo <= '0;
      r_result_hi <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_op  <= i_op;
        r_a   <= i_a;
        r_b   <= i_b;
        r_cnt <= '0;
        if (w_div0) begin
          // Divide by zero skips RUN entirely.
          r_state     <= ST_DONE;
          r_busy      <= 1'b0;
          r_done      <= 1'b1;
          r_err       <= 1'b1;
          r_result_lo <= {WIDTH{1'b1}};
          r_result_hi <= i_a;
        end else begin
          r_state <= ST_RUN;
          r_busy  <= 1'b1;
          r_err   <= 1'b0;
          // MUL keeps the multiplier in the low half of the accumulator;
          // DIV starts with a zero remainder and the dividend in r_quo.
          r_acc   <= (i_op == OP_MUL) ? {{(WIDTH+1){1'b0}}, i_b} : '0;
          r_quo   <= (i_op == OP_MUL) ? '0 : i_a;
        end
      end else begin
        case (r_state)
          ST_RUN: begin
            r_acc <= w_acc;
            r_quo <= w_quo;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              if (r_op == OP_MUL) begin
                r_result_lo <= w_acc[WIDTH-1:0];
                r_result_hi <= w_acc[2*WIDTH-1:WIDTH];
              end else begin
                r_result_lo <= w_quo;
                r_result_hi <= w_acc[WIDTH-1:0];
              end
            end
          end
          ST_DONE: r_state <= ST_IDLE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_result_lo = r_result_lo;
  assign o_result_hi = r_result_hi;

endmodule
